// File: rtl/rv_defs_pkg.sv
// Shared RV32M definitions: funct3 encodings, unit state encoding,
// datapath width and the fixed results for divide corner cases.
package rv_defs_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Quotient for any divide by zero; remainder in that case is the dividend.
  localparam logic [XLEN-1:0] MD_DIV0_QUOT = {XLEN{1'b1}};
  // Most-negative / -1 overflow: quotient saturates to the dividend, remainder 0.
  localparam logic [XLEN-1:0] MD_OVF_QUOT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MD_OVF_REM   = {XLEN{1'b0}};

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Arithmetic half of the multiply/divide unit: operand conditioning,
// 2N-bit shift-add / restoring-divide register, and sign fix-up.
// Sequenced entirely by load/step/finish strobes from muldiv_unit.
module md_datapath
  import rv_defs_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         finish_i,
  input  logic [2:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         special_o,
  output logic [N-1:0] result_o
);

  localparam logic [N-1:0] MIN_NEG = N'(MD_OVF_QUOT);

  logic           a_neg, b_neg;
  logic [N-1:0]   a_abs, b_abs;
  logic           div0, ovf;
  logic [N-1:0]   special_val;

  logic [2:0]     op_q;
  logic           neg_main_q;   // negate product / quotient
  logic           neg_rem_q;    // negate remainder
  logic [N-1:0]   opd_q;        // |A| for multiply, |B| for divide
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   result_q;

  logic [N:0]     mul_sum, rem_shift, rem_diff;
  logic [2*N-1:0] acc_step, prod;
  logic [N-1:0]   quot, rem, fixed;

  // Operand signs, magnitudes and early-out detection from the live inputs.
  always_comb begin
    a_neg     = md_a_signed(op_i) & a_i[N-1];
    b_neg     = md_b_signed(op_i) & b_i[N-1];
    a_abs     = a_neg ? -a_i : a_i;
    b_abs     = b_neg ? -b_i : b_i;
    div0      = op_i[2] && (b_i == '0);
    ovf       = op_i[2] && !op_i[0] && (a_i == MIN_NEG) && (b_i == '1);
    special_o = div0 | ovf;
    if (div0) special_val = op_i[1] ? a_i : N'(MD_DIV0_QUOT);
    else      special_val = op_i[1] ? N'(MD_OVF_REM) : N'(MD_OVF_QUOT);
  end

  // One iteration: multiply adds into the upper half and shifts right;
  // divide shifts the remainder left and keeps the trial subtract if it did not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    rem_shift = acc_q[2*N-1:N-1];
    rem_diff  = rem_shift - {1'b0, opd_q};
    if (op_q[2]) begin
      if (!rem_diff[N]) acc_step = {rem_diff[N-1:0], acc_q[N-2:0], 1'b1};
      else              acc_step = {rem_shift[N-1:0], acc_q[N-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[N-1:1]};
    end
  end

  // Sign fix-up and result selection, taken from the final iteration's value.
  always_comb begin
    prod = neg_main_q ? -acc_step : acc_step;
    quot = neg_main_q ? -acc_step[N-1:0] : acc_step[N-1:0];
    rem  = neg_rem_q ? -acc_step[2*N-1:N] : acc_step[2*N-1:N];
    case (op_q)
      MD_MUL:                       fixed = prod[N-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixed = prod[2*N-1:N];
      MD_DIV, MD_DIVU:              fixed = quot;
      default:                      fixed = rem;
    endcase
  end

  // Operand capture on load, iterate on step, write result on finish or early-out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q       <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      opd_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else if (load_i) begin
      op_q       <= op_i;
      neg_main_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      if (special_o) begin
        result_q <= special_val;
      end else begin
        acc_q <= {{N{1'b0}}, (op_i[2] ? a_abs : b_abs)};
        opd_q <= op_i[2] ? b_abs : a_abs;
      end
    end else if (step_i) begin
      acc_q <= acc_step;
      if (finish_i) result_q <= fixed;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit: control FSM and iteration counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands captured on acceptance
// CALC    | one multiplier/quotient bit per cycle, N cycles
// DONE    | result valid, done pulse; always returns to IDLE
module muldiv_unit
  import rv_defs_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] result_o
);

  localparam logic [5:0] CNT_LAST = 6'(N-1);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q;
  logic       last;
  logic       load, step, finish, special;

  assign last = (cnt_q == CNT_LAST);

  // State register and iteration counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load)      cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + 6'd1;
    end
  end

  // Next-state logic; corner-case divides skip CALC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start_i) state_d = special ? MD_DONE : MD_CALC;
      MD_CALC: if (last) state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Status outputs and datapath strobes decoded from the current state.
  always_comb begin
    busy_o = (state_q == MD_CALC) || (state_q == MD_DONE);
    done_o = (state_q == MD_DONE);
    load   = (state_q == MD_IDLE) && start_i;
    step   = (state_q == MD_CALC);
    finish = (state_q == MD_CALC) && last;
  end

  md_datapath #(.N(N)) u_datapath (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .step_i    (step),
    .finish_i  (finish),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .special_o (special),
    .result_o  (result_o)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes reference results and
// due cycles, a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  muldiv_unit #(.N(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic and native division semantics.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (done_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done actual=done with result %h required=no done (cycle %0d)", result_o, cyc);
      end else begin
        e = sb_q.pop_front();
        check32("result", result_o, e.res);
        check32("done_cycle", cyc, e.due);
        check32("busy_at_done", {31'd0, busy_o}, 32'd1);
      end
    end
  end

  // Issue one op at a negedge with the unit idle; returns at the first idle negedge.
  // inject >= 0 pulses a foreign start that many cycles after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inject);
    exp_t e;
    int   lat, w;
    lat   = ref_latency(op, a, b);
    e.res = ref_md(op, a, b);
    e.due = cyc + lat;
    sb_q.push_back(e);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk_i);
    start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    check32("busy_cycle1", {31'd0, busy_o}, 32'd1);
    w = 0;
    while (busy_o && w < 40) begin
      if (w == inject) begin
        start_i = 1'b1; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      w++;
    end
    start_i = 1'b0;
    check32("busy_length", w, lat);
    check32("result_held", result_o, e.res);
  endtask

  // Start a DIV, reset it at cycle k together with a competing start.
  task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input int k);
    start_i = 1'b1; op_i = 3'd4; a_i = a; b_i = b;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1; op_i = 3'd5; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0;
    check32("abort_busy", {31'd0, busy_o}, 32'd0);
    check32("abort_result", result_o, 32'd0);
    check32("abort_done", {31'd0, done_o}, 32'd0);
    for (int i = 0; i < 40; i++) @(negedge clk_i);
    check32("abort_idle_busy", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          mode, wq;
    rst_i = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk_i);
    check32("reset_busy", {31'd0, busy_o}, 32'd0);
    check32("reset_done", {31'd0, done_o}, 32'd0);
    check32("reset_result", result_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check32("idle_busy", {31'd0, busy_o}, 32'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd5, 32'd100, 32'd7, -1);
    run_op(3'd7, 32'd100, 32'd7, -1);
    run_op(3'd5, 32'h1234, 32'd0, -1);
    run_op(3'd7, 32'h1234, 32'd0, -1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);

    run_op(3'd5, 32'd100, 32'd7, 4);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'h1234_5678, 32'hDEAD_BEEF, 31);

    abort_op(32'hFFFF_FFF9, 32'd2, 10);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);

    for (int n = 0; n < 150; n++) begin
      rop  = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      ra   = $urandom;
      rb   = $urandom;
      case (mode)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
        3: begin ra = -$urandom_range(0, 300); rb = -$urandom_range(1, 20); end
        4: rb = $urandom_range(1, 16);
        default: ;
      endcase
      run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32)) : -1);
    end

    wq = 0;
    while (sb_q.size() != 0 && wq < 50) begin
      @(negedge clk_i);
      wq++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_expectations actual=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
